// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data bus responder: funct3 size/sign codes,
// FSM state encoding and the strb legality check.
package data_bus_responder_pkg;

  // funct3 size/sign codes; stores and loads share the low encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Codes 011/110/111 never exist; the unsigned variants are load-only.
  function automatic logic strb_illegal(input logic [2:0] code, input logic we);
    strb_illegal = (code == 3'b011) || (code[2:1] == 2'b11) || (we && code[2]);
  endfunction

endpackage

// File: rtl/data_bus_responder_ram.sv
// byte_lane_ram: DEPTH_WORDS x 32 storage with per-byte write enables.
//   clk_i   : write clock
//   be_i    : byte-lane write enables (bit i -> bits 8i+7:8i)
//   addr_i  : word index
//   wdata_i : lane-replicated write data
//   rdata_o : combinational read of the addressed word
// Contents are intentionally not reset.
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: single-outstanding load/store responder with a fixed
// number of wait states, byte/halfword/word access and error detection.
//   clk, reset         : clock, asynchronous active-high reset
//   busReq, busWe      : request strobe (sampled in IDLE), store/load select
//   busAddr, busWData  : byte address, right-aligned store data
//   strb               : funct3 size/sign code
//   busRData           : extended load result (RESP only, 0 otherwise)
//   busReady, busErr   : one-cycle completion pulse, error flag with it
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  strb,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  strb_q, strb_d;

  logic        err;
  logic [3:0]  lane_be;
  logic [3:0]  ram_be;
  logic [31:0] lane_wdata;
  logic [31:0] ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (busReq) begin
          we_d    = busWe;
          addr_d  = busAddr;
          wdata_d = busWData;
          strb_d  = strb;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access decode on the captured request
  always_comb begin
    err = strb_illegal(strb_q, we_q)
       || ((strb_q[1:0] == 2'b01) && addr_q[0])
       || ((strb_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00))
       || ((addr_q >> (AW + 2)) != '0);
    unique case (strb_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Write lands on the edge that ends RESP, so reset in WAIT/RESP drops it
  assign ram_be = (state_q == ST_RESP && we_q && !err) ? lane_be : '0;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk),
    .be_i    (ram_be),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (lane_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    byte_sel = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = ram_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (strb_q[1:0])
      2'b00:   load_data = strb_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = strb_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = ram_rdata;
    endcase
  end

  // Stores complete with zero read data
  assign busReady = (state_q == ST_RESP);
  assign busErr   = busReady && err;
  assign busRData = (busReady && !err && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  localparam int unsigned DEPTH = 256;
  // wait states per instance: inst0=1, inst1=3, inst2=0
  localparam logic [11:0] WCP = {4'd0, 4'd3, 4'd1};

  typedef struct {
    int          g;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [2:0]  st    [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        err   [3];

  logic [7:0]  mem_m [3][DEPTH*4];
  exp_t        sb[$];
  int          issued [3] = '{0, 0, 0};
  int          done   [3] = '{0, 0, 0};
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_bus_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(int'(WCP[g*4 +: 4]))
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .busReq   (req[g]),
      .busWe    (we[g]),
      .busAddr  (addr[g]),
      .busWData (wdat[g]),
      .strb     (st[g]),
      .busRData (rdata[g]),
      .busReady (rdy[g]),
      .busErr   (err[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'b00) return 1;
    if (s[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic w, input logic [31:0] a, input logic [2:0] s);
    if (s == 3'b011 || s == 3'b110 || s == 3'b111) return 1'b1;
    if (w && s >= 3'b100) return 1'b1;
    if ((a % nbytes(s)) != 0) return 1'b1;
    if (a >= DEPTH * 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int g, input logic [31:0] a, input logic [2:0] s);
    int n = nbytes(s);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[g][int'(a) + i]) << (8 * i));
    if (s < 3'b100 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (rdy[g] === 1'b1) begin
        if (sb.size() == 0 || sb[0].g != g) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ready inst%0d cycle %0d", g, cyc);
        end else begin
          e = sb.pop_front();
          vectors += 3;
          if (rdata[g] !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata inst%0d: got %h expected %h", g, rdata[g], e.rdata);
          end
          if (err[g] !== e.err) begin
            miscompares++;
            $display("FAIL err inst%0d: got %b expected %b", g, err[g], e.err);
          end
          if (cyc != e.cyc) begin
            miscompares++;
            $display("FAIL latency inst%0d: ready at cycle %0d expected %0d", g, cyc, e.cyc);
          end
          done[g]++;
        end
      end else begin
        vectors++;
        if (rdy[g] !== 1'b0 || rdata[g] !== 32'd0 || err[g] !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_outputs inst%0d: rdy=%b rdata=%h err=%b expected 0/0/0",
                   g, rdy[g], rdata[g], err[g]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_exp(input int g, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] s, input int when);
    exp_t e;
    e.g     = g;
    e.err   = model_err(w, a, s);
    e.rdata = (e.err || w) ? 32'd0 : model_load(g, a, s);
    e.cyc   = when;
    sb.push_back(e);
    issued[g]++;
    if (w && !e.err)
      for (int i = 0; i < nbytes(s); i++) mem_m[g][int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while (done[g] < issued[g] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done[g] < issued[g]) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout inst%0d: %0d responses expected %0d", g, done[g], issued[g]);
      sb.delete();
      done[g] = issued[g];
    end
  endtask

  task automatic access(input int g, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
    @(negedge clk);
    push_exp(g, w, a, d, s, cyc + 1 + int'(WCP[g*4 +: 4]));
    req[g] = 1'b1; we[g] = w; addr[g] = a; wdat[g] = d; st[g] = s;
    @(negedge clk);
    // scramble inputs after capture; they must not affect the response
    req[g] = 1'b0; we[g] = ~w; addr[g] = $urandom; wdat[g] = $urandom; st[g] = 3'($urandom);
    wait_done(g);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return DEPTH * 4 + $urandom_range(0, 15);
    return 32'($urandom_range(0, DEPTH * 4 - 1));
  endfunction

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0;
      addr[g] = '0; wdat[g] = '0; st[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;

    // fill every word so model and RAM agree everywhere
    for (int g = 0; g < 3; g++)
      for (int w = 0; w < int'(DEPTH); w++) access(g, 1'b1, 32'(w * 4), $urandom, 3'b010);

    // directed: word round-trip, byte merge, halfword, errors
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    access(0, 1'b0, 32'h10, 32'h0, 3'b010);
    access(0, 1'b1, 32'h20, 32'h0, 3'b010);
    access(0, 1'b1, 32'h22, 32'h80, 3'b000);
    access(0, 1'b0, 32'h22, 32'h0, 3'b000);
    access(0, 1'b0, 32'h22, 32'h0, 3'b100);
    access(0, 1'b0, 32'h20, 32'h0, 3'b010);
    access(0, 1'b1, 32'h32, 32'h8001, 3'b001);
    access(0, 1'b0, 32'h32, 32'h0, 3'b001);
    access(0, 1'b0, 32'h32, 32'h0, 3'b101);
    access(0, 1'b1, 32'h40, 32'hA5A5_5A5A, 3'b010);
    access(0, 1'b1, 32'h41, 32'h1111_2222, 3'b010);
    access(0, 1'b0, 32'h43, 32'h0, 3'b001);
    access(0, 1'b0, DEPTH * 4, 32'h0, 3'b010);
    access(0, 1'b1, 32'h42, 32'h3333, 3'b101);
    access(0, 1'b1, 32'h40, 32'h44, 3'b011);
    access(0, 1'b0, 32'h40, 32'h0, 3'b010);

    // reset during the second WAIT cycle of a store (3 wait states)
    access(1, 1'b1, 32'h50, 32'hCAFEF00D, 3'b010);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h50; wdat[1] = 32'h12345678; st[1] = 3'b010;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    vectors++;
    if (rdy[1] !== 1'b0 || rdata[1] !== 32'd0 || err[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b rdata=%h err=%b expected 0/0/0", rdy[1], rdata[1], err[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    access(1, 1'b0, 32'h50, 32'h0, 3'b010);

    // zero wait states with busReq held across back-to-back loads
    @(negedge clk);
    begin
      logic [31:0] a = 32'($urandom_range(0, DEPTH - 1) * 4);
      logic [2:0]  s = 3'b010;
      push_exp(2, 1'b0, a, 32'h0, s, cyc + 1);
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = a; st[2] = s;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        // now in RESP: the new values wait for the following IDLE edge
        a = rand_addr();
        s = 3'($urandom_range(0, 7));
        push_exp(2, 1'b0, a, 32'h0, s, cyc + 2);
        addr[2] = a; st[2] = s; wdat[2] = $urandom;
        @(negedge clk);
      end
      @(negedge clk);
      req[2] = 1'b0;
      wait_done(2);
    end

    // randomized mixed traffic
    for (int g = 0; g < 3; g++)
      for (int n = 0; n < 150; n++)
        access(g, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 3'($urandom_range(0, 7)));

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_expectations: %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the RAM (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of extra wait states per access (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port busReq, input, 1 bit: access request, sampled only in IDLE.
REQ-006 SHALL have port busWe, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port busAddr, input, 32 bits: byte address.
REQ-008 SHALL have port busWData, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port strb, input, 3 bits: the funct3 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port busRData, output, 32 bits: load result, extended.
REQ-011 SHALL have port busReady, output, 1 bit: one-cycle access-complete pulse.
REQ-012 SHALL have port busErr, output, 1 bit: valid with busReady; flags a misaligned, out-of-range or illegal-strb access.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; with WAIT_CYCLES=0, IDLE goes directly to RESP.
REQ-014 SHALL, in IDLE with busReq=1, capture busWe, busAddr, busWData and strb into registers.
- Input changes after capture are ignored until the FSM returns to IDLE.
REQ-015 SHALL, in WAIT, decrement a counter loaded with WAIT_CYCLES-1 and enter RESP when it reaches 0.
REQ-016 SHALL assert busReady for exactly one cycle, in RESP.
- Request sampled at edge N -> busReady high during cycle N+1+WAIT_CYCLES.
REQ-017 SHALL, in RESP, return to IDLE unconditionally; the next request is accepted no earlier than the following cycle.
REQ-018 SHALL commit stores on the clock edge ending RESP, using byte-lane enables:
- SB: lane = addr[1:0].
- SH: lanes {addr[1],0} and +1.
- SW: all four lanes.
- The data lane comes from the low bits of busWData.
REQ-019 SHALL present load data on busRData during RESP:
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- The selected byte/halfword is taken from the addr[1:0] lane.
REQ-020 SHALL treat the following as an error: halfword access with addr[0]=1; word access with addr[1:0]≠0; word index ≥ DEPTH_WORDS; or strb ∈ {011, 110, 111}, or strb ∈ {100, 101} on a store.
- On error: busErr=1 with busReady, no memory write, busRData=0.
REQ-021 SHALL drive busRData=0 and busErr=0 in every cycle outside RESP.
REQ-022 SHALL form the word index from addr[log2(DEPTH_WORDS)+1:2]; any nonzero upper address bits SHALL be an out-of-range error.

Reset
REQ-023 SHALL, on reset, force state=IDLE, counter=0, busReady=0, busErr=0, busRData=0 and clear all captured request registers.
REQ-024 SHALL, on reset asserted mid-access (WAIT or RESP), discard the pending store with no memory write.
REQ-025 SHALL NOT reset the RAM contents.

Structure
REQ-026 SHALL place the strb encodings (SB/SH/SW/LB/LH/LBU/LHU) and the FSM state enum typedef in the shared defines package.
REQ-027 SHALL implement the storage as one sub-module, byte_lane_ram: DEPTH_WORDS×32, 4-bit byte write enable, combinational read.

Verification
REQ-028 SHALL verify word round-trip:
- Stimulus: SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_CYCLES=1.
- Response: busReady 2 cycles after each request; busRData=0xDEADBEEF; busErr=0.
REQ-029 SHALL verify byte merge and extension:
- Stimulus: SW 0x00000000 @0x20, SB 0x80 @0x22, LB @0x22, LBU @0x22, LW @0x20.
- Response: 0xFFFFFF80, then 0x00000080, then 0x00800000.
REQ-030 SHALL verify halfword access:
- Stimulus: SH 0x8001 @0x32, LH @0x32, LHU @0x32.
- Response: 0xFFFF8001, then 0x00008001.
REQ-031 SHALL verify misaligned and out-of-range handling:
- Stimulus: SW @0x41, LH @0x43, LW @(DEPTH_WORDS*4).
- Response: each gives busErr=1, busRData=0; a following LW @0x40 shows memory unchanged.
REQ-032 SHALL verify reset mid-access:
- Stimulus: SW 0x12345678 @0x50 with WAIT_CYCLES=3; assert reset in the second WAIT cycle.
- Response: outputs immediately 0, FSM in IDLE; a following LW @0x50 returns the prior contents.
REQ-033 SHALL verify latency with no wait states and held request:
- Stimulus: WAIT_CYCLES=0, busReq held high across back-to-back loads.
- Response: busReady every other cycle; inputs changed during RESP are not captured.
